// File: rtl/ex_fwd_alu_core.sv
// EX-stage datapath core: RAW forwarding select, integer ALU, and EX/MEM
// capture flops for the ALU result and the forwarded store data.
module ex_fwd_alu_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      shamt,
    input  logic [5:0]      alu_control,
    input  logic            alu_src,
    input  logic [4:0]      ex_mem_rd,
    input  logic            ex_mem_reg_write,
    input  logic [XLEN-1:0] ex_mem_result,
    input  logic [4:0]      mem_wb_rd,
    input  logic            mem_wb_reg_write,
    input  logic [XLEN-1:0] mem_wb_result,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] result_q,
    output logic [XLEN-1:0] store_data_q
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [XLEN-1:0] fa, fb, opb;
    logic [XLEN-1:0] result_d, store_data_d;
    logic [XLEN-1:0] jalr_sum;

    // Forward select: the younger EX/MEM producer beats MEM/WB; x0 is never forwarded.
    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == rs1)
            forward_a = FWD_MEM;
        else if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == rs1)
            forward_a = FWD_WB;
        if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == rs2)
            forward_b = FWD_MEM;
        else if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == rs2)
            forward_b = FWD_WB;
    end

    // Operand muxes; store data is always the forwarded rs2, whatever alu_src says.
    always_comb begin
        unique case (forward_a)
            FWD_MEM: fa = ex_mem_result;
            FWD_WB:  fa = mem_wb_result;
            default: fa = read_data1;
        endcase
        unique case (forward_b)
            FWD_MEM: fb = ex_mem_result;
            FWD_WB:  fb = mem_wb_result;
            default: fb = read_data2;
        endcase
        opb          = alu_src ? imm : fb;
        store_data_d = fb;
    end

    // ALU: compares and branches yield exactly 0/1; branches always compare fa with fb.
    always_comb begin
        result_d = '0;
        jalr_sum = fa + imm;
        unique case (alu_control)
            6'h01: result_d = fa + opb;
            6'h02: result_d = fa - opb;
            6'h03: result_d = fa << opb[4:0];
            6'h04: result_d = {31'd0, $signed(fa) < $signed(opb)};
            6'h05: result_d = {31'd0, fa < opb};
            6'h06: result_d = fa ^ opb;
            6'h07: result_d = fa >> opb[4:0];
            6'h08: result_d = $signed(fa) >>> opb[4:0];
            6'h09: result_d = fa | opb;
            6'h0A: result_d = fa & opb;
            6'h0B: result_d = fa << shamt;
            6'h0C: result_d = fa >> shamt;
            6'h0D: result_d = $signed(fa) >>> shamt;
            6'h0E: result_d = {31'd0, fa == fb};
            6'h0F: result_d = {31'd0, fa != fb};
            6'h10: result_d = {31'd0, $signed(fa) < $signed(fb)};
            6'h11: result_d = {31'd0, $signed(fa) >= $signed(fb)};
            6'h12: result_d = {31'd0, fa < fb};
            6'h13: result_d = {31'd0, fa >= fb};
            6'h14: result_d = imm;
            6'h15: result_d = {jalr_sum[XLEN-1:1], 1'b0};
            default: result_d = '0;
        endcase
    end

    assign result     = result_d;
    assign store_data = store_data_d;

    // EX/MEM capture: unconditional load every cycle, async clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q     <= '0;
            store_data_q <= '0;
        end else begin
            result_q     <= result_d;
            store_data_q <= store_data_d;
        end
    end

endmodule

// File: tb/tb_ex_fwd_alu_core.sv
// Directed bench for ex_fwd_alu_core: forwarding priority, x0 guard, store
// forwarding, ALU op coverage, capture latency and asynchronous reset.
module tb_ex_fwd_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, shamt, ex_mem_rd, mem_wb_rd;
    logic [31:0] read_data1, read_data2, imm, ex_mem_result, mem_wb_result;
    logic [5:0]  alu_control;
    logic        alu_src, ex_mem_reg_write, mem_wb_reg_write;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] result, store_data, result_q, store_data_q;

    int tests = 0;
    int fails = 0;

    ex_fwd_alu_core #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .rs1(rs1), .rs2(rs2),
        .read_data1(read_data1), .read_data2(read_data2),
        .imm(imm), .shamt(shamt),
        .alu_control(alu_control), .alu_src(alu_src),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_result(mem_wb_result),
        .forward_a(forward_a), .forward_b(forward_b),
        .result(result), .store_data(store_data),
        .result_q(result_q), .store_data_q(store_data_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; shamt = 5'd0;
        read_data1 = 32'd0; read_data2 = 32'd0; imm = 32'd0;
        alu_control = 6'h00; alu_src = 1'b0;
        ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b0; ex_mem_result = 32'd0;
        mem_wb_rd = 5'd0; mem_wb_reg_write = 1'b0; mem_wb_result = 32'd0;
    endtask

    // Set plain register-file operands with no hazards.
    task automatic op(input logic [5:0] ctl, input logic [31:0] a, input logic [31:0] b);
        idle();
        rs1 = 5'd1; rs2 = 5'd2;
        read_data1 = a; read_data2 = b; alu_control = ctl;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #2;
        chk("reset_result_q", result_q, 32'd0);
        chk("reset_store_q", store_data_q, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // No hazard: 5 + 7
        @(negedge clk);
        op(6'h01, 32'd5, 32'd7);
        #1;
        chk("nohaz_fwd_a", {30'd0, forward_a}, 32'd0);
        chk("nohaz_fwd_b", {30'd0, forward_b}, 32'd0);
        chk("nohaz_result", result, 32'd12);
        @(posedge clk); #1;
        chk("nohaz_result_q", result_q, 32'd12);
        chk("nohaz_store_q", store_data_q, 32'd7);

        // Double hazard on rs1: EX/MEM wins
        @(negedge clk);
        op(6'h01, 32'h99, 32'h1);
        rs1 = 5'd3; rs2 = 5'd4;
        ex_mem_rd = 5'd3; ex_mem_reg_write = 1'b1; ex_mem_result = 32'h10;
        mem_wb_rd = 5'd3; mem_wb_reg_write = 1'b1; mem_wb_result = 32'h20;
        #1;
        chk("dbl_fwd_a", {30'd0, forward_a}, 32'b10);
        chk("dbl_fwd_b", {30'd0, forward_b}, 32'b00);
        chk("dbl_result", result, 32'h11);
        // Only MEM/WB writing
        ex_mem_reg_write = 1'b0;
        #1;
        chk("wb_fwd_a", {30'd0, forward_a}, 32'b01);
        chk("wb_result", result, 32'h21);

        // x0 guard on both stages
        @(negedge clk);
        op(6'h01, 32'h0, 32'h1234);
        rs2 = 5'd0;
        ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b1; ex_mem_result = 32'hDEAD;
        mem_wb_rd = 5'd0; mem_wb_reg_write = 1'b1; mem_wb_result = 32'hBEEF;
        #1;
        chk("x0_fwd_b", {30'd0, forward_b}, 32'b00);
        chk("x0_store", store_data, 32'h1234);

        // Store forwarding with immediate operand B
        @(negedge clk);
        op(6'h01, 32'h100, 32'h3);
        rs2 = 5'd6; alu_src = 1'b1; imm = 32'd8;
        mem_wb_rd = 5'd6; mem_wb_reg_write = 1'b1; mem_wb_result = 32'h55;
        ex_mem_rd = 5'd6; ex_mem_reg_write = 1'b0; ex_mem_result = 32'h77;
        #1;
        chk("st_fwd_b", {30'd0, forward_b}, 32'b01);
        chk("st_result", result, 32'h108);
        chk("st_store", store_data, 32'h55);
        @(posedge clk); #1;
        chk("st_store_q", store_data_q, 32'h55);

        // Branches compare with fb even when alu_src=1 (imm=-2 would flip BLT)
        @(negedge clk);
        op(6'h10, 32'hFFFF_FFFF, 32'd1);
        alu_src = 1'b1; imm = 32'hFFFF_FFFE;
        #1; chk("blt", result, 32'd1);
        alu_control = 6'h12; #1; chk("bltu", result, 32'd0);
        alu_control = 6'h13; #1; chk("bgeu", result, 32'd1);
        alu_control = 6'h11; #1; chk("bge", result, 32'd0);
        alu_control = 6'h0E; #1; chk("beq", result, 32'd0);
        alu_control = 6'h0F; #1; chk("bne", result, 32'd1);

        // Arithmetic / logic / shifts
        op(6'h02, 32'd5, 32'd7);          #1; chk("sub", result, 32'hFFFF_FFFE);
        op(6'h04, 32'hFFFF_FFFF, 32'd1);  #1; chk("slt", result, 32'd1);
        op(6'h05, 32'hFFFF_FFFF, 32'd1);  #1; chk("sltu", result, 32'd0);
        op(6'h06, 32'hF0F0_F0F0, 32'hFF00_FF00); #1; chk("xor", result, 32'h0FF0_0FF0);
        op(6'h09, 32'hF0F0_F0F0, 32'h0F00_0000); #1; chk("or", result, 32'hFFF0_F0F0);
        op(6'h0A, 32'hF0F0_F0F0, 32'hFF00_FF00); #1; chk("and", result, 32'hF000_F000);
        op(6'h03, 32'h0000_0003, 32'h0000_0024); #1; chk("sll", result, 32'h0000_0030);
        op(6'h07, 32'h8000_0000, 32'd4);  #1; chk("srl", result, 32'h0800_0000);
        op(6'h08, 32'h8000_0000, 32'd4);  #1; chk("sra", result, 32'hF800_0000);
        op(6'h0D, 32'h8000_0000, 32'd0); shamt = 5'd4; #1; chk("srai", result, 32'hF800_0000);
        op(6'h0C, 32'h8000_0000, 32'd1); shamt = 5'd4; #1; chk("srli", result, 32'h0800_0000);
        op(6'h0B, 32'h0000_0001, 32'd0); shamt = 5'd31; #1; chk("slli", result, 32'h8000_0000);
        op(6'h14, 32'h1, 32'h2); imm = 32'hABCD_E000; #1; chk("lui", result, 32'hABCD_E000);
        op(6'h15, 32'h101, 32'h7); imm = 32'd2; #1; chk("jalr", result, 32'h102);
        op(6'h3F, 32'h5, 32'h7); #1; chk("unlisted", result, 32'd0);

        // Async reset mid-cycle
        @(negedge clk);
        op(6'h01, 32'd4, 32'd5);
        @(posedge clk); #1;
        chk("pre_rst_q", result_q, 32'd9);
        #2; rst = 1'b0; #1;
        chk("rst_result_q", result_q, 32'd0);
        chk("rst_store_q", store_data_q, 32'd0);
        chk("rst_comb", result, 32'd9);
        @(posedge clk); #1;
        chk("rst_hold_q", result_q, 32'd0);
        @(negedge clk); rst = 1'b1;
        #1; chk("rel_before_edge", result_q, 32'd0);
        @(posedge clk); #1;
        chk("rel_result_q", result_q, 32'd9);
        chk("rel_store_q", store_data_q, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
